// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU front end: fetch states, datapath
// widths and the opcode field position used by the decoder and ALU.
package cpu_pkg;

    localparam int INSTR_W     = 16;
    localparam int MEM_DATA_W  = 8;
    localparam int ADDR_W_DFLT = 14;
    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 12;

    typedef enum logic [1:0] {
        ISSUE_HI   = 2'd0,
        ISSUE_LO   = 2'd1,
        CAPTURE_LO = 2'd2,
        VALID      = 2'd3
    } fetch_state_e;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads two bytes per instruction from byte-wide memory,
// assembles a big-endian 16-bit word and hands it over on a valid/ready port.
//
// state      | meaning
// ISSUE_HI   | present pc (high byte) to memory, or idle while halted
// ISSUE_LO   | present pc+1, latch the high byte returned for pc
// CAPTURE_LO | low byte arrives; assemble word, advance pc by 2
// VALID      | hold word until the consumer accepts it
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DFLT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd_en,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0]    instr,
    output logic [ADDR_W-1:0]     instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_addr,
    input  logic                  halt,
    output logic [15:0]           fetch_count
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [MEM_DATA_W-1:0] hi_q, hi_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic [ADDR_W-1:0]     instr_pc_q, instr_pc_d;
    logic                  valid_q, valid_d;
    logic [15:0]           count_q, count_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hi_d       = hi_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;
        mem_addr   = pc_q;
        mem_rd_en  = 1'b0;

        case (state_q)
            ISSUE_HI: begin
                if (!halt) begin
                    mem_rd_en = 1'b1;
                    state_d   = ISSUE_LO;
                end
            end
            ISSUE_LO: begin
                mem_addr  = pc_q + ADDR_W'(1);
                mem_rd_en = 1'b1;
                hi_d      = mem_rdata;
                state_d   = CAPTURE_LO;
            end
            CAPTURE_LO: begin
                instr_d    = {hi_q, mem_rdata};
                instr_pc_d = pc_q;
                pc_d       = pc_q + ADDR_W'(2);
                valid_d    = 1'b1;
                state_d    = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = ISSUE_HI;
                end
            end
            default: state_d = ISSUE_HI;
        endcase

        // A redirect squashes whatever is in flight, including a word being accepted.
        if (redirect_valid) begin
            pc_d    = {redirect_addr[ADDR_W-1:1], 1'b0};
            valid_d = 1'b0;
            hi_d    = '0;
            count_d = count_q;
            state_d = ISSUE_HI;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ISSUE_HI;
            pc_q       <= RESET_PC;
            hi_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hi_q       <= hi_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fetch_count = count_q;

endmodule
